offchip_rx: RTL

OFFCHIP_RX -- requirements
Module: offchip_rx

---
 rtl/offchip_rx.sv | 112 +++++++++++
 1 files changed

// File: rtl/offchip_rx.sv
// Off-chip 2-bit lane receiver: reassembles 4 symbols into a byte, buffers it in a
// small FIFO, presents it on a registered valid/ready output and returns one credit per byte taken.
module offchip_rx #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] lane_data,
  input  logic       lane_valid,
  input  logic       lane_sof,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready,
  output logic       credit,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_MSB = {1'b1, {(PTR_W-1){1'b0}}};

  logic [1:0]       sym_cnt_q, sym_cnt_d;
  logic [7:0]       part_q, part_d;
  logic [7:0]       byte_done;
  logic             byte_wr;
  logic             sof_err;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic             empty, full, push, pop, fire;

  logic [7:0]       data_q;
  logic             valid_q, credit_q, overflow_q, frame_err_q;

  // Symbol deframer: symbol k carries byte bits k (lane 0) and k+4 (lane 1).
  always_comb begin
    sym_cnt_d = sym_cnt_q;
    part_d    = part_q;
    byte_done = part_q;
    byte_wr   = 1'b0;
    sof_err   = 1'b0;
    if (lane_valid) begin
      if (lane_sof && (sym_cnt_q != 2'd0)) begin
        // Restart on the early sof: the partial byte is discarded.
        sof_err   = 1'b1;
        part_d    = {3'b000, lane_data[1], 3'b000, lane_data[0]};
        sym_cnt_d = 2'd1;
      end else begin
        byte_done[{1'b0, sym_cnt_q}] = lane_data[0];
        byte_done[{1'b1, sym_cnt_q}] = lane_data[1];
        part_d    = byte_done;
        sym_cnt_d = sym_cnt_q + 2'd1;
        byte_wr   = (sym_cnt_q == 2'd3);
      end
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q ^ rptr_q) == PTR_MSB);
  assign push  = byte_wr && !full;
  assign fire  = ready && valid_q;
  assign pop   = !empty && (!valid_q || fire);

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wptr_q[AW-1:0]] <= byte_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q   <= 2'd0;
      part_q      <= 8'h00;
      wptr_q      <= '0;
      rptr_q      <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      part_q    <= part_d;
      credit_q  <= fire;
      if (push) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (byte_wr && full) begin
        overflow_q <= 1'b1;
      end
      if (sof_err) begin
        frame_err_q <= 1'b1;
      end
      if (pop) begin
        data_q  <= mem[rptr_q[AW-1:0]];
        rptr_q  <= rptr_q + PTR_ONE;
        valid_q <= 1'b1;
      end else if (fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign credit    = credit_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
